// File: rtl/phase_bank_ctrl.sv
// -----------------------------------------------------------------------------
// phase_bank_ctrl
//
// Purpose:
//   Sequences a bank of N_CHANNELS transducer clock generators. A host command
//   port loads per-channel phase offsets and a shared half-period divide into
//   shadow registers. A commit copies every shadow to the active buses in a
//   single edge and holds the bank's active-low reset for HOLD_CYCLES cycles,
//   so every generator reloads its phase on the same edge. The block also owns
//   the bank-wide output enable.
//
// Ports:
//   clk        system clock (50 MHz)
//   rst        asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (IDLE only)
//   cmd_op     00 write offset, 01 write divide, 10 commit, 11 set output enable
//   cmd_ch     channel index (op 00 only)
//   cmd_data   payload: full offset (00), low OFFSET_WIDTH-1 bits (01), bit 0 (11)
//   offsets    active offsets, channel k at [k*OFFSET_WIDTH +: OFFSET_WIDTH]
//   divide     active shared divide
//   bank_rst   active-low reset to all generators
//   bank_oe    output enable to all generators
//   busy       commit (or post-reset hold) in progress
//   err        sticky command-rejected flag, cleared only by rst
//
// Build option:
//   PHASE_RANGE_CHECK_EN  when defined, offset writes whose count exceeds the
//   shadow divide, and divide writes that would leave a shadow offset past its
//   wrap point, are rejected and set err.
// -----------------------------------------------------------------------------
module phase_bank_ctrl #(
    parameter int N_CHANNELS     = 8,
    parameter int CH_WIDTH       = 3,
    parameter int OFFSET_WIDTH   = 11,
    parameter int DIVIDE_DEFAULT = 624,
    parameter int HOLD_CYCLES    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [1:0]                         cmd_op,
    input  logic [CH_WIDTH-1:0]                cmd_ch,
    input  logic [OFFSET_WIDTH-1:0]            cmd_data,
    output logic [N_CHANNELS*OFFSET_WIDTH-1:0] offsets,
    output logic [OFFSET_WIDTH-2:0]            divide,
    output logic                               bank_rst,
    output logic                               bank_oe,
    output logic                               busy,
    output logic                               err
);

    localparam int DW = OFFSET_WIDTH - 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DIV_RST   = DW'(DIVIDE_DEFAULT);

    localparam logic [1:0] OP_WR_OFFSET = 2'b00;
    localparam logic [1:0] OP_WR_DIVIDE = 2'b01;
    localparam logic [1:0] OP_COMMIT    = 2'b10;
    localparam logic [1:0] OP_SET_OE    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HOLD    = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    state_t                         state_q, state_d;
    logic [HW-1:0]                  hold_cnt_q, hold_cnt_d;
    logic [OFFSET_WIDTH-1:0]        shadow_q [N_CHANNELS];
    logic [OFFSET_WIDTH-1:0]        shadow_d [N_CHANNELS];
    logic [DW-1:0]                  shadow_div_q, shadow_div_d;
    logic [N_CHANNELS*OFFSET_WIDTH-1:0] offsets_q, offsets_d;
    logic [DW-1:0]                  divide_q, divide_d;
    logic                           bank_rst_q, bank_rst_d;
    logic                           bank_oe_q, bank_oe_d;
    logic                           busy_q, busy_d;
    logic                           ready_q, ready_d;
    logic                           err_q, err_d;

    // Command decode
    logic                  xfer;
    logic                  is_wr_off, is_wr_div, is_commit, is_set_oe;
    logic [N_CHANNELS-1:0] ch_hit;
    logic                  ch_ok;
    logic [DW-1:0]         new_div;
    logic                  div_zero;
    logic                  off_range_bad, div_range_bad;
    logic                  off_ok, div_ok;

    assign xfer      = cmd_valid && ready_q;
    assign is_wr_off = xfer && (cmd_op == OP_WR_OFFSET);
    assign is_wr_div = xfer && (cmd_op == OP_WR_DIVIDE);
    assign is_commit = xfer && (cmd_op == OP_COMMIT);
    assign is_set_oe = xfer && (cmd_op == OP_SET_OE);
    assign new_div   = cmd_data[DW-1:0];
    assign div_zero  = (new_div == '0);

    genvar gi;

    // One-hot channel match; an index with no match is out of range.
    generate
        for (gi = 0; gi < N_CHANNELS; gi++) begin : g_ch_hit
            assign ch_hit[gi] = (cmd_ch == CH_WIDTH'(gi));
        end
    endgenerate
    assign ch_ok = |ch_hit;

`ifdef PHASE_RANGE_CHECK_EN
    // A generator must never be loaded with a count beyond its wrap point.
    logic [N_CHANNELS-1:0] over_new_div;
    generate
        for (gi = 0; gi < N_CHANNELS; gi++) begin : g_over_div
            assign over_new_div[gi] = (shadow_q[gi][DW-1:0] > new_div);
        end
    endgenerate
    assign off_range_bad = (cmd_data[DW-1:0] > shadow_div_q);
    assign div_range_bad = |over_new_div;
`else
    assign off_range_bad = 1'b0;
    assign div_range_bad = 1'b0;
`endif

    assign off_ok = ch_ok && !off_range_bad;
    assign div_ok = !div_zero && !div_range_bad;

    // ---------------------------------------------------------------- FSM --
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (is_commit) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Status outputs are registered copies of the next state so they change
    // on the same edge as the state itself.
    always_comb begin
        bank_rst_d = (state_d != ST_HOLD);
        busy_d     = (state_d != ST_IDLE);
        ready_d    = (state_d == ST_IDLE);
    end

    // ----------------------------------------------------------- datapath --
    always_comb begin
        for (int k = 0; k < N_CHANNELS; k++) begin
            shadow_d[k] = shadow_q[k];
        end
        shadow_div_d = shadow_div_q;
        offsets_d    = offsets_q;
        divide_d     = divide_q;
        bank_oe_d    = bank_oe_q;
        err_d        = err_q;

        if (is_wr_off) begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                if (off_ok && ch_hit[k]) begin
                    shadow_d[k] = cmd_data;
                end
            end
            if (!off_ok) begin
                err_d = 1'b1;
            end
        end

        if (is_wr_div) begin
            if (div_ok) begin
                shadow_div_d = new_div;
            end else begin
                err_d = 1'b1;
            end
        end

        // Every shadow lands on the active buses in the same edge.
        if (is_commit) begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                offsets_d[k*OFFSET_WIDTH +: OFFSET_WIDTH] = shadow_q[k];
            end
            divide_d = shadow_div_q;
        end

        if (is_set_oe) begin
            bank_oe_d = cmd_data[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                shadow_q[k] <= '0;
            end
            shadow_div_q <= DIV_RST;
            offsets_q    <= '0;
            divide_q     <= DIV_RST;
            bank_rst_q   <= 1'b0;
            bank_oe_q    <= 1'b0;
            busy_q       <= 1'b1;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
            shadow_div_q <= shadow_div_d;
            offsets_q    <= offsets_d;
            divide_q     <= divide_d;
            bank_rst_q   <= bank_rst_d;
            bank_oe_q    <= bank_oe_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    assign cmd_ready = ready_q;
    assign offsets   = offsets_q;
    assign divide    = divide_q;
    assign bank_rst  = bank_rst_q;
    assign bank_oe   = bank_oe_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_phase_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phase_bank_ctrl
//
// Self-checking bench for phase_bank_ctrl. A behavioural model tracks shadow
// and active state; each accepted commit pushes the expected active buses into
// a scoreboard queue, which is popped and compared once the DUT has applied
// the commit. The channel index port is widened to 4 bits so that an
// out-of-range channel (9) can be driven.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_phase_bank_ctrl;

    localparam int N    = 8;
    localparam int CHW  = 4;
    localparam int OW   = 11;
    localparam int DW   = OW - 1;
    localparam int HOLD = 4;
    localparam logic [DW-1:0] DIV_DEF = 10'd624;
`ifdef PHASE_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [CHW-1:0]    cmd_ch = '0;
    logic [OW-1:0]     cmd_data = '0;
    logic [N*OW-1:0]   offsets;
    logic [DW-1:0]     divide;
    logic              bank_rst, bank_oe, busy, err;

    always #10 clk = ~clk;

    phase_bank_ctrl #(
        .N_CHANNELS(N), .CH_WIDTH(CHW), .OFFSET_WIDTH(OW),
        .DIVIDE_DEFAULT(624), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data),
        .offsets(offsets), .divide(divide), .bank_rst(bank_rst),
        .bank_oe(bank_oe), .busy(busy), .err(err)
    );

    int vectors = 0;
    int miscompares = 0;

    // ------------------------------------------------------------- model --
    typedef struct packed {
        logic [N*OW-1:0] offs;
        logic [DW-1:0]   div;
    } snap_t;

    snap_t           sb[$];
    logic [OW-1:0]   m_shadow [N];
    logic [DW-1:0]   m_sdiv;
    logic [N*OW-1:0] m_act_offs;
    logic [DW-1:0]   m_act_div;
    logic            m_err, m_oe;

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_shadow[k] = '0;
        m_sdiv     = DIV_DEF;
        m_act_offs = '0;
        m_act_div  = DIV_DEF;
        m_err      = 1'b0;
        m_oe       = 1'b0;
        sb.delete();
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [CHW-1:0] ch,
                               input logic [OW-1:0] data);
        snap_t s;
        bit    bad;
        case (op)
            2'b00: begin
                bad = (int'(ch) >= N) || (RANGE_EN && (data[DW-1:0] > m_sdiv));
                if (bad) m_err = 1'b1;
                else     m_shadow[int'(ch)] = data;
            end
            2'b01: begin
                bad = (data[DW-1:0] == '0);
                if (RANGE_EN)
                    for (int k = 0; k < N; k++)
                        if (m_shadow[k][DW-1:0] > data[DW-1:0]) bad = 1'b1;
                if (bad) m_err = 1'b1;
                else     m_sdiv = data[DW-1:0];
            end
            2'b10: begin
                for (int k = 0; k < N; k++) s.offs[k*OW +: OW] = m_shadow[k];
                s.div      = m_sdiv;
                m_act_offs = s.offs;
                m_act_div  = s.div;
                sb.push_back(s);
            end
            default: m_oe = data[0];
        endcase
    endtask

    // Called at a negedge. Presents the command, waits (bounded) for ready,
    // lets it transfer on the next posedge and returns at the following
    // negedge. waited = number of negedges spent with ready low.
    task automatic send_cmd(input logic [1:0] op, input logic [CHW-1:0] ch,
                            input logic [OW-1:0] data, output int waited);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_data  = data;
        waited    = 0;
        while (cmd_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout op=%b: cmd_ready got %b want 1 within 40 cycles", op, cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_apply(op, ch, data);
            #1 cmd_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------- tests --
    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bank_rst !== 1'b0) begin miscompares++; $display("FAIL rst_bank_rst: got %b want 0", bank_rst); end
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy: got %b want 1", busy); end
        vectors++; if (offsets !== '0) begin miscompares++; $display("FAIL rst_offsets: got %h want 0", offsets); end
        vectors++; if (divide !== DIV_DEF) begin miscompares++; $display("FAIL rst_divide: got %0d want %0d", divide, DIV_DEF); end
        vectors++; if (bank_oe !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rst_oe_err: got oe=%b err=%b want 0 0", bank_oe, err); end
        rst = 1'b1;
        for (int i = 1; i < HOLD; i++) begin
            @(negedge clk);
            vectors++;
            if (bank_rst !== 1'b0 || cmd_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL rel_hold c%0d: got bank_rst=%b ready=%b want 0 0", i, bank_rst, cmd_ready);
            end
        end
        @(negedge clk);
        vectors++;
        if (bank_rst !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rel_release: got bank_rst=%b ready=%b busy=%b want 1 0 1", bank_rst, cmd_ready, busy);
        end
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || bank_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL rel_idle: got ready=%b busy=%b bank_rst=%b want 1 0 1", cmd_ready, busy, bank_rst);
        end
    endtask

    task automatic test_commit();
        int    w;
        snap_t s;
        send_cmd(2'b00, 4'd3, 11'h4FF, w);
        send_cmd(2'b00, 4'd0, 11'h0A0, w);
        vectors++; if (offsets !== m_act_offs) begin miscompares++; $display("FAIL commit_pre_offsets: got %h want %h", offsets, m_act_offs); end
        vectors++; if (bank_rst !== 1'b1) begin miscompares++; $display("FAIL commit_pre_bank_rst: got %b want 1", bank_rst); end
        send_cmd(2'b10, 4'd0, 11'h000, w);   // returns just after edge T
        if (sb.size() == 0) begin
            vectors++; miscompares++; $display("FAIL commit_sb_empty: got 0 entries want 1");
        end else begin
            s = sb.pop_front();
            vectors++; if (offsets !== s.offs) begin miscompares++; $display("FAIL commit_offsets: got %h want %h", offsets, s.offs); end
            vectors++; if (divide !== s.div) begin miscompares++; $display("FAIL commit_divide: got %0d want %0d", divide, s.div); end
        end
        vectors++; if (offsets[3*OW +: OW] !== 11'h4FF || offsets[0 +: OW] !== 11'h0A0) begin
            miscompares++; $display("FAIL commit_slices: got ch3=%h ch0=%h want 4ff 0a0", offsets[3*OW +: OW], offsets[0 +: OW]); end
        vectors++; if (bank_rst !== 1'b0 || cmd_ready !== 1'b0) begin
            miscompares++; $display("FAIL commit_T: got bank_rst=%b ready=%b want 0 0", bank_rst, cmd_ready); end
        for (int i = 1; i < HOLD; i++) begin
            @(negedge clk);
            vectors++;
            if (bank_rst !== 1'b0 || offsets !== m_act_offs) begin
                miscompares++;
                $display("FAIL commit_hold T+%0d: got bank_rst=%b offsets=%h want 0 %h", i, bank_rst, offsets, m_act_offs);
            end
        end
        @(negedge clk);
        vectors++; if (bank_rst !== 1'b1 || cmd_ready !== 1'b0) begin
            miscompares++; $display("FAIL commit_T+%0d: got bank_rst=%b ready=%b want 1 0", HOLD, bank_rst, cmd_ready); end
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL commit_T+%0d: got ready=%b busy=%b want 1 0", HOLD + 1, cmd_ready, busy); end
    endtask

    task automatic test_stall();
        int    w;
        snap_t s;
        send_cmd(2'b10, 4'd0, 11'h000, w);
        if (sb.size() != 0) s = sb.pop_front();
        // Presented right after the commit edge; must wait for ready.
        send_cmd(2'b00, 4'd1, 11'h123, w);
        vectors++; if (w !== HOLD + 1) begin
            miscompares++; $display("FAIL stall_ready_delay: got %0d cycles after T want %0d", w, HOLD + 1); end
        vectors++; if (offsets[1*OW +: OW] !== 11'h000) begin
            miscompares++; $display("FAIL stall_slice1_pre: got %h want 000", offsets[1*OW +: OW]); end
        send_cmd(2'b10, 4'd0, 11'h000, w);
        if (sb.size() == 0) begin
            vectors++; miscompares++; $display("FAIL stall_sb_empty: got 0 entries want 1");
        end else begin
            s = sb.pop_front();
            vectors++; if (offsets !== s.offs) begin miscompares++; $display("FAIL stall_offsets: got %h want %h", offsets, s.offs); end
        end
        vectors++; if (offsets[1*OW +: OW] !== 11'h123) begin
            miscompares++; $display("FAIL stall_slice1_post: got %h want 123", offsets[1*OW +: OW]); end
    endtask

    task automatic test_oe();
        int w;
        send_cmd(2'b11, 4'd0, 11'h001, w);
        vectors++; if (bank_oe !== 1'b1 || bank_rst !== 1'b1 || cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL oe_on: got oe=%b bank_rst=%b ready=%b want 1 1 1", bank_oe, bank_rst, cmd_ready); end
        send_cmd(2'b11, 4'd0, 11'h7FE, w);
        vectors++; if (bank_oe !== 1'b0 || bank_rst !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL oe_off: got oe=%b bank_rst=%b busy=%b want 0 1 0", bank_oe, bank_rst, busy); end
    endtask

    task automatic test_errors();
        int    w;
        snap_t s;
        do_reset();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear_after_rst: got %b want 0", err); end
        send_cmd(2'b01, 4'd0, 11'h400, w);   // low bits zero
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_zero_div: got %b want 1", err); end
        send_cmd(2'b10, 4'd0, 11'h000, w);
        if (sb.size() != 0) begin
            s = sb.pop_front();
            vectors++; if (divide !== s.div) begin miscompares++; $display("FAIL err_zero_div_kept: got %0d want %0d", divide, s.div); end
        end
        do_reset();
        send_cmd(2'b00, 4'd9, 11'h7FF, w);
        vectors++; if (err !== m_err) begin miscompares++; $display("FAIL err_bad_ch: got %b want %b", err, m_err); end
        send_cmd(2'b01, 4'd0, 11'd300, w);
        send_cmd(2'b10, 4'd0, 11'h000, w);
        if (sb.size() != 0) begin
            s = sb.pop_front();
            vectors++; if (offsets !== s.offs) begin miscompares++; $display("FAIL err_bad_ch_dropped: got %h want %h", offsets, s.offs); end
            vectors++; if (divide !== s.div) begin miscompares++; $display("FAIL err_div300: got %0d want %0d", divide, s.div); end
        end
        repeat (8) @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_range();
        int    w;
        snap_t s;
        do_reset();
        send_cmd(2'b01, 4'd0, 11'd100, w);
        send_cmd(2'b00, 4'd2, 11'h065, w);
        vectors++; if (err !== m_err) begin miscompares++; $display("FAIL range_065: got err=%b want %b", err, m_err); end
        send_cmd(2'b00, 4'd2, 11'h464, w);
        send_cmd(2'b10, 4'd0, 11'h000, w);
        if (sb.size() == 0) begin
            vectors++; miscompares++; $display("FAIL range_sb_empty: got 0 entries want 1");
        end else begin
            s = sb.pop_front();
            vectors++; if (offsets !== s.offs || divide !== s.div) begin
                miscompares++; $display("FAIL range_commit: got %h/%0d want %h/%0d", offsets, divide, s.offs, s.div); end
        end
        vectors++; if (offsets[2*OW +: OW] !== 11'h464) begin
            miscompares++; $display("FAIL range_464: got %h want 464", offsets[2*OW +: OW]); end
    endtask

    task automatic test_back_to_back();
        int    w;
        snap_t s;
        logic [CHW-1:0] ch;
        logic [OW-1:0]  d;
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 3; j++) begin
                ch = CHW'($urandom_range(0, N - 1));
                d  = OW'($urandom_range(0, 2047));
                send_cmd(2'b00, ch, d, w);
            end
            send_cmd(2'b01, 4'd0, OW'($urandom_range(0, 2047)), w);
            send_cmd(2'b10, 4'd0, 11'h000, w);
            if (sb.size() == 0) begin
                vectors++; miscompares++; $display("FAIL b2b_sb_empty r%0d: got 0 entries want 1", r);
            end else begin
                s = sb.pop_front();
                vectors++; if (offsets !== s.offs) begin miscompares++; $display("FAIL b2b_offsets r%0d: got %h want %h", r, offsets, s.offs); end
                vectors++; if (divide !== s.div) begin miscompares++; $display("FAIL b2b_divide r%0d: got %0d want %0d", r, divide, s.div); end
            end
            vectors++; if (err !== m_err) begin miscompares++; $display("FAIL b2b_err r%0d: got %b want %b", r, err, m_err); end
        end
        // Two commits with nothing between them.
        send_cmd(2'b10, 4'd0, 11'h000, w);
        send_cmd(2'b10, 4'd0, 11'h000, w);
        while (sb.size() > 1) s = sb.pop_front();
        if (sb.size() != 0) begin
            s = sb.pop_front();
            vectors++; if (offsets !== s.offs || divide !== s.div) begin
                miscompares++; $display("FAIL b2b_double_commit: got %h/%0d want %h/%0d", offsets, divide, s.offs, s.div); end
        end
        vectors++; if (w !== HOLD + 1) begin miscompares++; $display("FAIL b2b_second_commit_wait: got %0d want %0d", w, HOLD + 1); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_stall();
        test_oe();
        test_errors();
        test_range();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
